// File: rtl/add8_mon_pkg.sv
// Shared widths and FSM encoding for the 8-bit approximate-adder error monitor.
package add8_mon_pkg;

    localparam int OP_W  = 8;
    localparam int SUM_W = 9;
    localparam int ED_W  = 9;
    localparam int SQ_W  = 18;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } mon_state_t;

endpackage

// File: rtl/add8_err_calc.sv
// Stage 1: registers the absolute distance between the exact sum and the adder output.
module add8_err_calc
    import add8_mon_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             acc_i,
    input  logic [OP_W-1:0]  a_i,
    input  logic [OP_W-1:0]  b_i,
    input  logic [SUM_W-1:0] o_i,
    output logic [ED_W-1:0]  ed_o,
    output logic             v1_o
);

    logic [SUM_W-1:0] exact;
    logic [ED_W-1:0]  ed_d;
    logic [ED_W-1:0]  ed_q;
    logic             v1_q;

    assign exact = {1'b0, a_i} + {1'b0, b_i};
    assign ed_d  = (exact >= o_i) ? (exact - o_i) : (o_i - exact);

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            ed_q <= '0;
        end else begin
            v1_q <= acc_i;
            if (acc_i) begin
                ed_q <= ed_d;
            end
        end
    end

    assign ed_o = ed_q;
    assign v1_o = v1_q;

endmodule

// File: rtl/add8_err_monitor.sv
// Streaming error monitor: accepts NUM_SAMPLES (A, B, O) samples and accumulates
// MAE/MSE numerators, worst-case error and error count for an approximate adder.
module add8_err_monitor
    import add8_mon_pkg::*;
#(
    parameter int NUM_SAMPLES = 65536,
    parameter int CNT_W       = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OP_W-1:0]       A,
    input  logic [OP_W-1:0]       B,
    input  logic [SUM_W-1:0]      O,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      sample_cnt,
    output logic [CNT_W-1:0]      err_cnt,
    output logic [CNT_W+9-1:0]    sum_ed,
    output logic [CNT_W+18-1:0]   sum_sq,
    output logic [ED_W-1:0]       max_ed,
    output mon_state_t            dbg_state,
    output logic [1:0]            dbg_pipe
);

    localparam logic [CNT_W-1:0] N_L = CNT_W'(NUM_SAMPLES);

    mon_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       err_q, err_d;
    logic [CNT_W+9-1:0]     sum_ed_q, sum_ed_d;
    logic [CNT_W+18-1:0]    sum_sq_q, sum_sq_d;
    logic [ED_W-1:0]        max_q, max_d;
    logic                   v2_q, v2_d;

    logic                   accept;
    logic                   start_run;
    logic [ED_W-1:0]        ed;
    logic                   v1;
    logic [SQ_W-1:0]        ed_sq;

    // Handshake: a sample transfers on any rising edge where in_valid && in_ready;
    // in_ready depends only on registered state, never on in_valid.
    assign in_ready  = (state_q == ST_RUN) && (cnt_q < N_L);
    assign accept    = in_valid && in_ready;
    assign start_run = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    add8_err_calc u_calc (
        .clk   (clk),
        .rst   (rst),
        .acc_i (accept),
        .a_i   (A),
        .b_i   (B),
        .o_i   (O),
        .ed_o  (ed),
        .v1_o  (v1)
    );

    assign ed_sq = {9'd0, ed} * {9'd0, ed};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        sum_ed_d = sum_ed_q;
        sum_sq_d = sum_sq_q;
        max_d    = max_q;
        v2_d     = v1;

        case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN:   if (accept && (cnt_q == N_L - 1'b1)) state_d = ST_DRAIN;
            // Stage 2 commits on the edge v1 drops, so the stats are final here.
            ST_DRAIN: if (!v1) state_d = ST_DONE;
            ST_DONE:  if (start) state_d = ST_RUN;
            default:  state_d = ST_IDLE;
        endcase

        if (start_run) begin
            cnt_d    = '0;
            err_d    = '0;
            sum_ed_d = '0;
            sum_sq_d = '0;
            max_d    = '0;
        end else begin
            if (accept) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (v1) begin
                sum_ed_d = sum_ed_q + {{CNT_W{1'b0}}, ed};
                sum_sq_d = sum_sq_q + {{CNT_W{1'b0}}, ed_sq};
                err_d    = err_q + {{(CNT_W-1){1'b0}}, |ed};
                if (ed > max_q) begin
                    max_d = ed;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            err_q    <= '0;
            sum_ed_q <= '0;
            sum_sq_q <= '0;
            max_q    <= '0;
            v2_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            sum_ed_q <= sum_ed_d;
            sum_sq_q <= sum_sq_d;
            max_q    <= max_d;
            v2_q     <= v2_d;
        end
    end

    assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done       = (state_q == ST_DONE);
    assign sample_cnt = cnt_q;
    assign err_cnt    = err_q;
    assign sum_ed     = sum_ed_q;
    assign sum_sq     = sum_sq_q;
    assign max_ed     = max_q;
    assign dbg_state  = state_q;
    assign dbg_pipe   = {v2_q, v1};

endmodule

// File: tb/tb_add8_err_monitor.sv
// Directed bench for add8_err_monitor: five instances with different run lengths
// share one sample bus; only one instance is running at any time.
module tb_add8_err_monitor;
    import add8_mon_pkg::*;

    localparam int CNT_W = 17;
    localparam int NI    = 5;
    localparam int I1    = 0;
    localparam int I4    = 1;
    localparam int I8    = 2;
    localparam int I16   = 3;
    localparam int IBIG  = 4;

    logic clk;
    logic rst;
    logic in_valid;
    logic [7:0] A;
    logic [7:0] B;
    logic [8:0] O;

    logic                start_s    [NI];
    logic                in_ready   [NI];
    logic                busy       [NI];
    logic                done       [NI];
    logic [CNT_W-1:0]    sample_cnt [NI];
    logic [CNT_W-1:0]    err_cnt    [NI];
    logic [CNT_W+8:0]    sum_ed     [NI];
    logic [CNT_W+17:0]   sum_sq     [NI];
    logic [8:0]          max_ed     [NI];
    mon_state_t          dbg_state  [NI];
    logic [1:0]          dbg_pipe   [NI];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [8:0]  o;
        logic [8:0]  ed;
        logic [17:0] sq;
    } vec_t;

    vec_t tbl [6];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int NS = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 8 : (g == 3) ? 16 : 65536;
        add8_err_monitor #(.NUM_SAMPLES(NS), .CNT_W(CNT_W)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .start      (start_s[g]),
            .in_valid   (in_valid),
            .in_ready   (in_ready[g]),
            .A          (A),
            .B          (B),
            .O          (O),
            .busy       (busy[g]),
            .done       (done[g]),
            .sample_cnt (sample_cnt[g]),
            .err_cnt    (err_cnt[g]),
            .sum_ed     (sum_ed[g]),
            .sum_sq     (sum_sq[g]),
            .max_ed     (max_ed[g]),
            .dbg_state  (dbg_state[g]),
            .dbg_pipe   (dbg_pipe[g])
        );
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int g);
        start_s[g] = 1'b1;
        tick();
        start_s[g] = 1'b0;
    endtask

    // driver: present one sample and hold it until the target instance takes it
    task automatic send(input int g, input logic [7:0] a, input logic [7:0] b, input logic [8:0] o);
        int n;
        n = 0;
        A = a;
        B = b;
        O = o;
        in_valid = 1'b1;
        while (!in_ready[g] && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready[g]) check("send_ready_timeout", 64'(in_ready[g]), 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int g);
        int n;
        n = 0;
        while (!done[g] && n < 20) begin
            tick();
            n++;
        end
        check("wait_done", 64'(done[g]), 64'd1);
    endtask

    task automatic check_stats(input int g, input string tag, input logic [63:0] cnt,
                               input logic [63:0] err, input logic [63:0] sed,
                               input logic [63:0] ssq, input logic [63:0] mx);
        check({tag, "_sample_cnt"}, 64'(sample_cnt[g]), cnt);
        check({tag, "_err_cnt"},    64'(err_cnt[g]),    err);
        check({tag, "_sum_ed"},     64'(sum_ed[g]),     sed);
        check({tag, "_sum_sq"},     64'(sum_sq[g]),     ssq);
        check({tag, "_max_ed"},     64'(max_ed[g]),     mx);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;

        tbl[0] = '{a: 8'd3,   b: 8'd5,   o: 9'd3,     ed: 9'd5,   sq: 18'd25};
        tbl[1] = '{a: 8'd0,   b: 8'd0,   o: 9'h1FF,   ed: 9'd511, sq: 18'd261121};
        tbl[2] = '{a: 8'd255, b: 8'd255, o: 9'd510,   ed: 9'd0,   sq: 18'd0};
        tbl[3] = '{a: 8'd255, b: 8'd255, o: 9'd0,     ed: 9'd510, sq: 18'd260100};
        tbl[4] = '{a: 8'd100, b: 8'd50,  o: 9'd140,   ed: 9'd10,  sq: 18'd100};
        tbl[5] = '{a: 8'd0,   b: 8'd1,   o: 9'd0,     ed: 9'd1,   sq: 18'd1};

        rst = 1'b1;
        in_valid = 1'b0;
        A = '0;
        B = '0;
        O = '0;
        for (int g = 0; g < NI; g++) start_s[g] = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // reset state
        for (int g = 0; g < NI; g++) begin
            check("rst_in_ready", 64'(in_ready[g]), 64'd0);
            check("rst_busy",     64'(busy[g]),     64'd0);
            check("rst_done",     64'(done[g]),     64'd0);
        end
        check_stats(I16, "rst", 0, 0, 0, 0, 0);

        // exact-sum run, N=16
        pulse_start(I16);
        check("n16_busy", 64'(busy[I16]), 64'd1);
        for (int i = 0; i < 16; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            send(I16, ra, rb, {1'b0, ra} + {1'b0, rb});
        end
        wait_done(I16);
        check_stats(I16, "exact16", 16, 0, 0, 0, 0);

        // N=1 latency: accept at edge E, done at E+2
        pulse_start(I1);
        A = 8'd3;
        B = 8'd5;
        O = 9'd3;
        in_valid = 1'b1;
        check("n1_ready_pre", 64'(in_ready[I1]), 64'd1);
        tick();
        in_valid = 1'b0;
        check("n1_ready_post", 64'(in_ready[I1]), 64'd0);
        check("n1_cnt_e0",     64'(sample_cnt[I1]), 64'd1);
        check("n1_done_e0",    64'(done[I1]), 64'd0);
        tick();
        check("n1_done_e1",    64'(done[I1]), 64'd0);
        check("n1_busy_e1",    64'(busy[I1]), 64'd1);
        tick();
        check("n1_done_e2",    64'(done[I1]), 64'd1);
        check("n1_busy_e2",    64'(busy[I1]), 64'd0);
        check_stats(I1, "n1", 1, 1, 5, 25, 5);

        // single-sample table, each row its own run
        for (int i = 0; i < 6; i++) begin
            pulse_start(I1);
            check("tbl_cleared", 64'(sum_ed[I1]), 64'd0);
            send(I1, tbl[i].a, tbl[i].b, tbl[i].o);
            wait_done(I1);
            check_stats(I1, $sformatf("tbl%0d", i), 1, (tbl[i].ed != 0) ? 1 : 0,
                        64'(tbl[i].ed), 64'(tbl[i].sq), 64'(tbl[i].ed));
        end

        // N=4 with gaps, start in RUN ignored
        pulse_start(I4);
        send(I4, 8'd10, 8'd10, 9'd21);
        pulse_start(I4);
        check("n4_start_ignored", 64'(sample_cnt[I4]), 64'd1);
        check("n4_still_busy",    64'(busy[I4]), 64'd1);
        tick();
        send(I4, 8'd10, 8'd10, 9'd18);
        send(I4, 8'd0,  8'd0,  9'd3);
        tick();
        send(I4, 8'd50, 8'd50, 9'd96);
        wait_done(I4);
        check_stats(I4, "n4", 4, 4, 10, 30, 4);

        // reset mid-run on N=8
        pulse_start(I8);
        for (int i = 0; i < 3; i++) send(I8, 8'd1, 8'd1, 9'd0);
        tick();
        tick();
        check("n8_pre_rst_sum", 64'(sum_ed[I8]), 64'd6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("n8_rst_state", 64'(dbg_state[I8]), 64'(ST_IDLE));
        check("n8_rst_ready", 64'(in_ready[I8]), 64'd0);
        check("n8_rst_busy",  64'(busy[I8]), 64'd0);
        check("n8_rst_done",  64'(done[I8]), 64'd0);
        check_stats(I8, "n8_rst", 0, 0, 0, 0, 0);
        pulse_start(I8);
        for (int i = 0; i < 8; i++) begin
            ra = 8'(i * 10);
            send(I8, ra, 8'd5, 9'(i * 11 + 5));
        end
        wait_done(I8);
        check_stats(I8, "n8", 8, 7, 28, 140, 7);

        // exhaustive A/B with O off by one, streamed back to back
        pulse_start(IBIG);
        for (int i = 0; i < 65536; i++) begin
            ra = 8'(i);
            rb = 8'(i >> 8);
            A = ra;
            B = rb;
            O = ({1'b0, ra} + {1'b0, rb} + 9'd1);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("big_ready_end", 64'(in_ready[IBIG]), 64'd0);
        wait_done(IBIG);
        check_stats(IBIG, "big", 65536, 65536, 65536, 65536, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
